// File: rtl/cache_refill_if.sv
// rtl/cache_refill_if.sv - miss request, memory read/return and storage-table write signals of the refill engine
interface cache_refill_if #(
    parameter int NUM_WAY        = 2,
    parameter int BYTES_PER_LINE = 16,
    parameter int NUM_LINE       = 256
);
    localparam int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE);
    localparam int INDEX_WIDTH    = $clog2(NUM_LINE);
    localparam int TAG_WIDTH      = 32 - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int WORDS_PER_LINE = BYTES_PER_LINE / 4;
    localparam int BANK_NUM_WIDTH = $clog2(WORDS_PER_LINE);

    // miss request from the cache controller
    logic                      req_valid;
    logic                      req_ready;
    logic [31:0]               req_addr;
    logic [NUM_WAY-1:0]        req_way;
    logic                      req_store;
    logic [31:0]               req_wdata;
    logic [3:0]                req_wstrb;

    // line read request and return channel of the bus bridge
    logic                      rd_req;
    logic                      rd_rdy;
    logic [31:0]               rd_addr;
    logic                      ret_valid;
    logic                      ret_last;
    logic [31:0]               ret_data;

    // cache storage table write side
    logic                      write;
    logic [NUM_WAY-1:0]        write_way;
    logic [INDEX_WIDTH-1:0]    write_index;
    logic [BANK_NUM_WIDTH-1:0] write_bank_num;
    logic [31:0]               write_data;
    logic [3:0]                write_strb;
    logic [NUM_WAY-1:0]        tag_v_write_way;
    logic [TAG_WIDTH-1:0]      tag_write;
    logic                      v_write;
    logic [NUM_WAY-1:0]        d_write_way;
    logic                      d_write;

    // status
    logic                      done;
    logic [31:0]               resp_data;
    logic                      busy;
    logic                      proto_err;

    // refill engine side
    modport master (
        input  req_valid, req_addr, req_way, req_store, req_wdata, req_wstrb,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output req_ready, rd_req, rd_addr,
        output write, write_way, write_index, write_bank_num, write_data, write_strb,
        output tag_v_write_way, tag_write, v_write, d_write_way, d_write,
        output done, resp_data, busy, proto_err
    );

    // controller / bridge / storage side
    modport slave (
        output req_valid, req_addr, req_way, req_store, req_wdata, req_wstrb,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  req_ready, rd_req, rd_addr,
        input  write, write_way, write_index, write_bank_num, write_data, write_strb,
        input  tag_v_write_way, tag_write, v_write, d_write_way, d_write,
        input  done, resp_data, busy, proto_err
    );
endinterface

// File: rtl/cache_refill.sv
// rtl/cache_refill.sv - cache line-fill engine with store merge into the refilled line
module cache_refill #(
    parameter int NUM_WAY        = 2,
    parameter int BYTES_PER_LINE = 16,
    parameter int NUM_LINE       = 256
) (
    input  logic                 clk,
    input  logic                 resetn,
    cache_refill_if.master       bus
);
    localparam int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE);
    localparam int INDEX_WIDTH    = $clog2(NUM_LINE);
    localparam int TAG_WIDTH      = 32 - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int WORDS_PER_LINE = BYTES_PER_LINE / 4;
    localparam int BANK_NUM_WIDTH = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    state_t                    state, state_nxt;
    logic [TAG_WIDTH-1:0]      cap_tag;
    logic [INDEX_WIDTH-1:0]    cap_index;
    logic [BANK_NUM_WIDTH-1:0] cap_word;
    logic [NUM_WAY-1:0]        cap_way;
    logic                      cap_store;
    logic [31:0]               cap_wdata;
    logic [3:0]                cap_wstrb;
    logic [BANK_NUM_WIDTH-1:0] beat_cnt;
    logic [31:0]               resp_q;
    logic                      err_q;

    logic                      accept;
    logic                      beat;
    logic                      last_word;
    logic                      merge_hit;
    logic [31:0]               byte_mask;

    assign accept    = bus.req_valid && (state == IDLE);
    assign beat      = (state == RECV) && bus.ret_valid;
    assign last_word = (beat_cnt == BANK_NUM_WIDTH'(WORDS_PER_LINE - 1));
    assign merge_hit = cap_store && (beat_cnt == cap_word);

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // next-state: request, wait for bridge, collect beats until ret_last, pulse done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid)                  state_nxt = REQ;
            REQ:  if (bus.rd_rdy)                     state_nxt = RECV;
            RECV: if (bus.ret_valid && bus.ret_last)  state_nxt = DONE;
            DONE:                                     state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    // capture the miss on acceptance and advance the beat counter per returned word
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_tag   <= '0;
            cap_index <= '0;
            cap_word  <= '0;
            cap_way   <= '0;
            cap_store <= 1'b0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            beat_cnt  <= '0;
        end else if (accept) begin
            cap_tag   <= bus.req_addr[31 -: TAG_WIDTH];
            cap_index <= bus.req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
            cap_word  <= bus.req_addr[OFFSET_WIDTH-1:2];
            cap_way   <= bus.req_way;
            cap_store <= bus.req_store;
            cap_wdata <= bus.req_wdata;
            cap_wstrb <= bus.req_wstrb;
            beat_cnt  <= '0;
        end else if (beat) begin
            beat_cnt  <= beat_cnt + 1'b1;
        end
    end

    // keep the raw memory word of the requested offset and flag beat-count violations
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (beat && (beat_cnt == cap_word)) resp_q <= bus.ret_data;
            // early ret_last, or the counter wrapping without ret_last
            if (beat && (bus.ret_last != last_word)) err_q <= 1'b1;
        end
    end

    // expand the store byte enables to a bit mask
    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{cap_wstrb[b]}};
    end

    // storage-table write side; tag/valid/dirty selects only fire on the final beat
    always_comb begin
        bus.write           = beat;
        bus.write_way       = cap_way;
        bus.write_index     = cap_index;
        bus.write_bank_num  = beat_cnt;
        bus.write_data      = merge_hit ? ((bus.ret_data & ~byte_mask) | (cap_wdata & byte_mask))
                                        : bus.ret_data;
        bus.write_strb      = 4'hf;
        bus.tag_v_write_way = (beat && bus.ret_last) ? cap_way : '0;
        bus.d_write_way     = (beat && bus.ret_last) ? cap_way : '0;
        bus.tag_write       = cap_tag;
        bus.v_write         = 1'b1;
        bus.d_write         = cap_store;
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rd_req    = (state == REQ);
    assign bus.rd_addr   = {cap_tag, cap_index, {OFFSET_WIDTH{1'b0}}};
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.resp_data = resp_q;
    assign bus.proto_err = err_q;
endmodule
